// File: rtl/bcd_countdown_timer_gen.sv
// rtl/bcd_countdown_timer_gen.sv - N-digit mixed-radix BCD up/down timer with load, pause, long-press clear and blinking expiry
module bcd_countdown_timer_gen #(
    parameter int                        NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS-1:0]     RADIX6_MASK = 4'b0010,
    parameter logic [4*NUM_DIGITS-1:0]   DEFAULT_VAL = 16'h2359,
    parameter int                        HOLD_CYCLES = 3,
    parameter int                        LED_W       = 15
) (
    input  logic                      clk_1,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      run_toggle,
    input  logic                      dir,
    input  logic                      hold_clear,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      running,
    output logic                      expired,
    output logic [LED_W-1:0]          endled
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic            phase;

    logic [W-1:0]    term_val;
    logic [W-1:0]    stepped;
    logic [W-1:0]    clamped;
    logic [W-1:0]    load_digits;
    logic            at_term;
    logic            clear_fire;

    function automatic logic [3:0] digit_max(input int i);
        return RADIX6_MASK[i] ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] max_value();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = digit_max(i);
        return r;
    endfunction

    // Ripple a single +1/-1 through the digits; each digit wraps at its own radix.
    function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= digit_max(i)) d = 4'd0;
                    else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) d = digit_max(i);
                    else begin
                        d = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
        return r;
    endfunction

    always_comb begin
        term_val    = dir ? max_value() : '0;
        at_term     = (digits == term_val);
        stepped     = step(digits, dir);
        clamped     = clamp(load_val);
        load_digits = (clamped == '0) ? DEFAULT_VAL : clamped;
        clear_fire  = hold_clear && (hold_cnt == HW'(HOLD_CYCLES - 1));
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            digits   <= DEFAULT_VAL;
            state    <= IDLE;
            running  <= 1'b0;
            expired  <= 1'b0;
            endled   <= '0;
            hold_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            if (!hold_clear)
                hold_cnt <= '0;
            else if (hold_cnt != HW'(HOLD_CYCLES))
                hold_cnt <= hold_cnt + 1'b1;

            if (clear_fire || load) begin
                digits  <= clear_fire ? DEFAULT_VAL : load_digits;
                state   <= IDLE;
                running <= 1'b0;
                expired <= 1'b0;
                endled  <= '0;
                phase   <= 1'b0;
            end else if (state == DONE) begin
                phase  <= ~phase;
                endled <= {LED_W{~phase}};
            end else if (run_toggle) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else if (at_term) begin
                    state   <= DONE;
                    expired <= 1'b1;
                    phase   <= 1'b1;
                    endled  <= '1;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (state == RUN) begin
                // A dir flip can leave the current value already terminal: stop without stepping.
                if (!at_term)
                    digits <= stepped;
                if (at_term || stepped == term_val) begin
                    state   <= DONE;
                    running <= 1'b0;
                    expired <= 1'b1;
                    phase   <= 1'b1;
                    endled  <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer_gen.sv
// tb/tb_bcd_countdown_timer_gen.sv - directed plus randomized check against a mixed-radix integer model
module tb_bcd_countdown_timer_gen;

    localparam logic [3:0]  MASK = 4'b0010;
    localparam logic [15:0] DEF  = 16'h2359;
    localparam int          HOLD = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk_1 = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] load_val;
    logic        run_toggle;
    logic        dir;
    logic        hold_clear;
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic [14:0] endled;

    int n_checks = 0;
    int n_fail   = 0;

    int m_val, m_st, m_hold;
    bit m_phase;

    bcd_countdown_timer_gen dut (
        .clk_1      (clk_1),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .run_toggle (run_toggle),
        .dir        (dir),
        .hold_clear (hold_clear),
        .digits     (digits),
        .running    (running),
        .expired    (expired),
        .endled     (endled)
    );

    always #5 clk_1 = ~clk_1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int radix(input int i);
        logic [3:0] m;
        m = MASK;
        return m[i] ? 6 : 10;
    endfunction

    function automatic int total();
        int t;
        t = 1;
        for (int i = 0; i < 4; i++) t *= radix(i);
        return t;
    endfunction

    // Packed BCD -> position in the mixed-radix sequence, clamping out-of-range digits.
    function automatic int enc(input logic [15:0] v);
        int acc, w, d;
        acc = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > radix(i) - 1) d = radix(i) - 1;
            acc += d * w;
            w *= radix(i);
        end
        return acc;
    endfunction

    function automatic logic [15:0] dec(input int n);
        logic [15:0] r;
        int x;
        x = n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % radix(i));
            x = x / radix(i);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = enc(DEF);
        m_st = S_IDLE;
        m_hold = 0;
        m_phase = 0;
    endtask

    task automatic enter_done();
        m_st = S_DONE;
        m_phase = 1;
    endtask

    task automatic model_step();
        int term;
        bit fire;
        term = dir ? total() - 1 : 0;
        fire = hold_clear && (m_hold == HOLD - 1);
        m_hold = hold_clear ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 0;
        if (fire) begin
            m_val = enc(DEF); m_st = S_IDLE; m_phase = 0;
        end else if (load) begin
            m_val = enc(load_val);
            if (m_val == 0) m_val = enc(DEF);
            m_st = S_IDLE; m_phase = 0;
        end else if (m_st == S_DONE) begin
            m_phase = !m_phase;
        end else if (run_toggle) begin
            if (m_st == S_RUN) m_st = S_PAUSE;
            else if (m_val == term) enter_done();
            else m_st = S_RUN;
        end else if (m_st == S_RUN) begin
            if (m_val == term) enter_done();
            else begin
                m_val = dir ? m_val + 1 : m_val - 1;
                if (m_val == term) enter_done();
            end
        end
    endtask

    task automatic check_outputs();
        chk("digits", 32'(digits), 32'(dec(m_val)));
        chk("running", 32'(running), 32'(m_st == S_RUN));
        chk("expired", 32'(expired), 32'(m_st == S_DONE));
        chk("endled", 32'(endled), (m_st == S_DONE && m_phase) ? 32'h7FFF : 32'h0);
    endtask

    task automatic tick();
        @(posedge clk_1);
        model_step();
        @(negedge clk_1);
        check_outputs();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_toggle();
        run_toggle = 1'b1;
        tick();
        run_toggle = 1'b0;
    endtask

    task automatic do_async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_digits", 32'(digits), 32'h2359);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; load = 0; load_val = '0; run_toggle = 0; dir = 0; hold_clear = 0;
        model_reset();
        @(negedge clk_1);
        check_outputs();
        chk("reset_digits", 32'(digits), 32'h2359);
        rst_n = 1'b1;

        // Countdown to expiry and blink pattern
        do_load(16'h0003);
        do_toggle();
        chk("run_start", 32'(digits), 32'h0003);
        tick(); tick(); tick();
        chk("expire_val", 32'(digits), 32'h0000);
        chk("expire_flag", 32'(expired), 32'h1);
        chk("blink0", 32'(endled), 32'h7FFF);
        tick(); chk("blink1", 32'(endled), 32'h0);
        tick(); chk("blink2", 32'(endled), 32'h7FFF);

        // Borrow across radix-6 and radix-10 digits
        do_load(16'h0100); do_toggle(); tick();
        chk("borrow_0100", 32'(digits), 32'h0059);
        do_load(16'h1000); do_toggle(); tick();
        chk("borrow_1000", 32'(digits), 32'h0959);

        do_load(16'h0000); chk("load_zero", 32'(digits), 32'h2359);
        do_load(16'h0087); chk("load_clamp", 32'(digits), 32'h0057);

        // Pause / resume
        do_load(16'h0005); do_toggle(); tick(); tick();
        do_toggle();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("paused", 32'(digits), 32'h0003);
        end
        do_toggle(); tick();
        chk("resume", 32'(digits), 32'h0002);

        // Up count to terminal, DONE ignores toggle, long-press clear
        dir = 1'b1;
        do_load(16'h9957); do_toggle(); tick(); tick();
        chk("up_term", 32'(digits), 32'h9959);
        chk("up_done", 32'(expired), 32'h1);
        do_toggle();
        chk("done_toggle", 32'(expired), 32'h1);
        hold_clear = 1'b1; tick(); tick();
        hold_clear = 1'b0; tick();
        chk("short_hold", 32'(digits), 32'h9959);
        hold_clear = 1'b1; tick(); tick(); tick();
        chk("clear_val", 32'(digits), 32'h2359);
        chk("clear_led", 32'(endled), 32'h0);
        tick(); tick();
        hold_clear = 1'b0;
        dir = 1'b0;

        // Load beats toggle; async reset mid-run
        do_load(16'h0042); do_toggle(); tick();
        load = 1'b1; load_val = 16'h0130; run_toggle = 1'b1;
        tick();
        load = 1'b0; run_toggle = 1'b0;
        chk("load_wins", 32'(digits), 32'h0130);
        chk("load_wins_run", 32'(running), 32'h0);
        do_toggle(); tick();
        do_async_reset();
        chk("rst_running", 32'(running), 32'h0);

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) do_async_reset();
            if ($urandom_range(0, 5) == 0) hold_clear = ~hold_clear;
            if ($urandom_range(0, 24) == 0) dir = ~dir;
            run_toggle = ($urandom_range(0, 5) == 0);
            load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: load_val = 16'($urandom);
                1: load_val = dec($urandom_range(0, 4));
                2: load_val = dec(total() - 1 - $urandom_range(0, 4));
                default: load_val = 16'h0000;
            endcase
            tick();
        end
        load = 0; run_toggle = 0; hold_clear = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
